// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit and the control
// unit that drives it.
//   mdu_op_t      : 2-bit operation code (also used by the control decoder)
//   OP_*          : operation encodings
//   mdu_state_t   : sequencer states of the unit
//   cond_negate   : two's-complement negate-if helper used for operand
//                   magnitudes and for the sign fix-up of results
// ---------------------------------------------------------------------------
package mdu_pkg;

   typedef logic [1:0] mdu_op_t;

   localparam mdu_op_t OP_MULT  = 2'b00;
   localparam mdu_op_t OP_MULTU = 2'b01;
   localparam mdu_op_t OP_DIV   = 2'b10;
   localparam mdu_op_t OP_DIVU  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
      FIX,
      DONE
   } mdu_state_t;

   // Working width of the helper. Callers zero-extend into it and truncate
   // the result back with a size cast; negation modulo 2^MDU_XW truncated to
   // N bits equals negation modulo 2^N, so one helper serves every width.
   // This bounds the unit to WIDTH <= 64 (the product is 2*WIDTH bits).
   localparam int MDU_XW = 128;

   function automatic logic [MDU_XW-1:0] cond_negate(input logic [MDU_XW-1:0] x,
                                                     input logic              neg);
      return neg ? (MDU_XW'(0) - x) : x;
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if
// Request/response bundle between the control unit (master) and the
// multiply/divide unit (slave).
//   start, op, a, b            : request, driven by the master
//   busy, done, div_zero,
//   hi, lo                     : status and results, driven by the unit
// ---------------------------------------------------------------------------
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   import mdu_pkg::*;

   logic             start;
   mdu_op_t          op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, div_zero, hi, lo
   );

endinterface

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative signed/unsigned multiply and divide producing the HI/LO pair.
// One result bit per cycle over a shared 2*WIDTH accumulator; a normal op
// takes WIDTH+1 cycles, divide-by-zero finishes in one and keeps HI/LO.
//   clk    : rising-edge clock
//   reset  : synchronous, active-low
//   bus    : slave side of mult_div_unit_if
//            start/op/a/b sampled in IDLE only
//            busy while iterating or fixing up, done one-cycle pulse,
//            div_zero/hi/lo held until the next done
// Legal for 2 <= WIDTH <= 64.
// ---------------------------------------------------------------------------
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           reset,
   mult_div_unit_if.slave bus
);
   import mdu_pkg::*;

   localparam int CW = $clog2(WIDTH + 1);
   localparam int DW = 2 * WIDTH;

   mdu_state_t       state_q, state_d;
   logic [DW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic             div_q, div_d;
   logic             neg_q, neg_d;
   logic             neg_rem_q, neg_rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             div_zero_q, div_zero_d;

   logic             req_signed;
   logic             req_div;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_shift;
   logic             rem_ge;
   logic [WIDTH-1:0] rem_diff;
   logic [DW-1:0]    prod_fix;
   logic [WIDTH-1:0] quot_fix;
   logic [WIDTH-1:0] rem_fix;

   // Request decode and one iteration step of each datapath. The multiply
   // keeps the multiplier in the low half and adds the multiplicand into the
   // high half (with carry) before shifting right. The divide shifts the
   // remainder/dividend pair left and subtracts the divisor when it fits,
   // shifting the quotient bit into the low half. The remainder never
   // exceeds the divisor, so the trial difference fits in WIDTH bits.
   always_comb begin
      req_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
      req_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
      mag_a      = WIDTH'(cond_negate(MDU_XW'(bus.a), req_signed & bus.a[WIDTH-1]));
      mag_b      = WIDTH'(cond_negate(MDU_XW'(bus.b), req_signed & bus.b[WIDTH-1]));

      mul_sum    = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

      rem_shift  = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
      rem_ge     = rem_shift >= {1'b0, opnd_q};
      rem_diff   = rem_shift[WIDTH-1:0] - opnd_q;

      prod_fix   = DW'(cond_negate(MDU_XW'(acc_q), neg_q));
      quot_fix   = WIDTH'(cond_negate(MDU_XW'(acc_q[WIDTH-1:0]), neg_q));
      rem_fix    = WIDTH'(cond_negate(MDU_XW'(acc_q[DW-1:WIDTH]), neg_rem_q));
   end

   // Sequencer. IDLE captures magnitudes and the result sign flags so the
   // iterations are purely unsigned; FIX restores signs (the flags are
   // already zero for unsigned ops) and is the only place HI/LO are written.
   // The most-negative dividend over -1 needs no special case: its magnitude
   // quotient 2^(WIDTH-1) is not negated and reads back as the wrapped value.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      div_d      = div_q;
      neg_d      = neg_q;
      neg_rem_d  = neg_rem_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               div_d     = req_div;
               neg_d     = req_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               neg_rem_d = req_signed & bus.a[WIDTH-1];
               cnt_d     = '0;
               if (req_div && (bus.b == '0)) begin
                  div_zero_d = 1'b1;
                  state_d    = DONE;
               end else if (req_div) begin
                  acc_d   = {{WIDTH{1'b0}}, mag_a};
                  opnd_d  = mag_b;
                  state_d = DIV;
               end else begin
                  acc_d   = {{WIDTH{1'b0}}, mag_b};
                  opnd_d  = mag_a;
                  state_d = MUL;
               end
            end
         end
         MUL: begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end
         DIV: begin
            acc_d = {(rem_ge ? rem_diff : rem_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (div_q) begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end else begin
               hi_d = prod_fix[DW-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            div_zero_d = 1'b0;
            state_d    = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial result.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         opnd_q     <= '0;
         div_q      <= 1'b0;
         neg_q      <= 1'b0;
         neg_rem_q  <= 1'b0;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         div_q      <= div_d;
         neg_q      <= neg_d;
         neg_rem_q  <= neg_rem_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         div_zero_q <= div_zero_d;
      end
   end

   // Outputs come straight from registered state, never from the inputs.
   assign bus.busy     = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
   assign bus.done     = (state_q == DONE);
   assign bus.div_zero = div_zero_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule
